// File: rtl/wrb_arbiter.sv
// Writeback arbiter: six per-source FIFOs drained onto two regfile write ports, round-robin.
// Latency: 1 cycle minimum from accept to write port (no same-cycle bypass).
// Backpressure: src_ready_o[k] drops when FIFO k is full (registered count, no pop-through).
// Optional feature macro: WRB_STALL_CNT_EN adds a saturating 32-bit stall counter output.
module wrb_arbiter #(
    parameter int REG_SIZE_WIDTH = 6,
    parameter int DATA_WIDTH     = 64,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [5:0]                    src_valid_i,
    output logic [5:0]                    src_ready_o,
    input  logic [6*REG_SIZE_WIDTH-1:0]   src_addr_i,
    input  logic [6*DATA_WIDTH-1:0]       src_data_i,
`ifdef WRB_STALL_CNT_EN
    output logic [31:0]                   stall_cnt_o,
`endif
    output logic                          wr_first_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]     wr_first_address_o,
    output logic [DATA_WIDTH-1:0]         wr_first_data_o,
    output logic                          wr_second_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]     wr_second_address_o,
    output logic [DATA_WIDTH-1:0]         wr_second_data_o
);

    localparam int NSRC  = 6;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = REG_SIZE_WIDTH + DATA_WIDTH;

    // Entry layout: {addr, data}; storage is deliberately left unreset.
    logic [ENT_W-1:0] mem [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr [NSRC];
    logic [PTR_W-1:0] wr_ptr [NSRC];
    logic [CNT_W-1:0] cnt    [NSRC];
    logic [2:0]       rr_ptr;

    logic [NSRC-1:0]  ready;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;
    logic [NSRC-1:0]  not_empty;
    logic             first_vld;
    logic             second_vld;
    logic [2:0]       first_idx;
    logic [2:0]       second_idx;
    logic [ENT_W-1:0] first_head;
    logic [ENT_W-1:0] second_head;

    // (base + off) mod 6 for the round-robin scan and pointer update.
    function automatic logic [2:0] rr_idx(input logic [2:0] base, input int off);
        logic [3:0] s;
        s = {1'b0, base} + 4'(off);
        if (s >= 4'd6) s = s - 4'd6;
        return s[2:0];
    endfunction

    assign src_ready_o = ready;

    // Ready from registered count only; address-0 beats handshake but are dropped (P0 is hardwired).
    always_comb begin
        ready     = '0;
        push      = '0;
        not_empty = '0;
        for (int k = 0; k < NSRC; k++) begin
            ready[k]     = (cnt[k] != CNT_W'(FIFO_DEPTH));
            push[k]      = src_valid_i[k] && ready[k] &&
                           (src_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] != '0);
            not_empty[k] = (cnt[k] != '0);
        end
    end

    // Scan from rr_ptr: first non-empty source feeds port 0, the next one feeds port 1.
    always_comb begin
        logic [2:0] idx;
        first_vld  = 1'b0;
        second_vld = 1'b0;
        first_idx  = '0;
        second_idx = '0;
        idx        = '0;
        for (int i = 0; i < NSRC; i++) begin
            idx = rr_idx(rr_ptr, i);
            if (not_empty[idx]) begin
                if (!first_vld) begin
                    first_vld = 1'b1;
                    first_idx = idx;
                end else if (!second_vld) begin
                    second_vld = 1'b1;
                    second_idx = idx;
                end
            end
        end
    end

    // Drive the write ports from the granted heads; ungranted ports are forced to zero.
    always_comb begin
        first_head          = mem[first_idx][rd_ptr[first_idx]];
        second_head         = mem[second_idx][rd_ptr[second_idx]];
        wr_first_valid_o    = first_vld;
        wr_first_address_o  = first_vld  ? first_head[ENT_W-1:DATA_WIDTH]  : '0;
        wr_first_data_o     = first_vld  ? first_head[DATA_WIDTH-1:0]      : '0;
        wr_second_valid_o   = second_vld;
        wr_second_address_o = second_vld ? second_head[ENT_W-1:DATA_WIDTH] : '0;
        wr_second_data_o    = second_vld ? second_head[DATA_WIDTH-1:0]     : '0;
        pop                 = '0;
        for (int k = 0; k < NSRC; k++) begin
            pop[k] = (first_vld && (first_idx == 3'(k))) ||
                     (second_vld && (second_idx == 3'(k)));
        end
    end

    // FIFO pointers/counts and round-robin pointer; push+pop on one FIFO leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSRC; k++) begin
                cnt[k]    <= '0;
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int k = 0; k < NSRC; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
                case ({push[k], pop[k]})
                    2'b10:   cnt[k] <= cnt[k] + 1'b1;
                    2'b01:   cnt[k] <= cnt[k] - 1'b1;
                    default: cnt[k] <= cnt[k];
                endcase
            end
            if (second_vld)     rr_ptr <= rr_idx(second_idx, 1);
            else if (first_vld) rr_ptr <= rr_idx(first_idx, 1);
        end
    end

    // Entry storage written at the tail on accept.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NSRC; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= {src_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH],
                                      src_data_i[k*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

`ifdef WRB_STALL_CNT_EN
    // Count cycles in which any source is held off; saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if ((|(src_valid_i & ~ready)) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
